// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner: drives rows active-low, debounces whole-frame results,
// and holds each decoded key press in a one-entry valid/ack buffer.
module keypad_scanner #(
    parameter int SCAN_DIV = 250,
    parameter int DEBOUNCE = 4
) (
    input  logic       gclk,
    input  logic       rst,
    input  logic [2:0] keypadc,
    output logic [3:0] keypadr,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ack,
    output logic       key_down,
    output logic       overrun
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;
    localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DB_TARGET = CW'(DEBOUNCE);

    typedef enum logic {
        ST_IDLE,
        ST_PRESSED
    } state_t;

    // Lowest closed column wins; only meaningful when exactly one contact is closed.
    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [2:0] closed);
        logic [1:0] col;
        logic [3:0] code;
        col = closed[0] ? 2'd0 : (closed[1] ? 2'd1 : 2'd2);
        if (row == 2'd3) begin
            case (col)
                2'd0:    code = 4'hE;
                2'd1:    code = 4'h0;
                default: code = 4'hF;
            endcase
        end else begin
            code = {2'b00, row} * 4'd3 + {2'b00, col} + 4'd1;
        end
        return code;
    endfunction

    logic [2:0]    r_sync1;
    logic [2:0]    r_sync2;
    logic          r_active;
    logic [1:0]    r_row;
    logic [SW-1:0] r_slot;
    logic [1:0]    r_hits;
    logic [3:0]    r_hit_code;
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_cand;
    logic [3:0]    r_key_code;
    logic          r_key_valid;
    logic          r_overrun;

    logic          w_slot_end;
    logic          w_frame_end;
    logic [2:0]    w_closed;
    logic [1:0]    w_row_hits;
    logic [3:0]    w_row_code;
    logic [2:0]    w_sum;
    logic [1:0]    w_acc_hits;
    logic [3:0]    w_acc_code;
    logic          w_single;
    logic [CW-1:0] w_cnt_inc;
    state_t        w_state_nx;
    logic [CW-1:0] w_cnt_nx;
    logic [3:0]    w_cand_nx;
    logic          w_press;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge gclk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 3'b111;
            r_sync2 <= 3'b111;
        end else begin
            r_sync1 <= keypadc;
            r_sync2 <= r_sync1;
        end
    end

    // r_active holds the rows released for the reset cycle, so row 0 gets a full slot.
    always_ff @(posedge gclk or posedge rst) begin
        if (rst) begin
            r_active <= 1'b0;
            r_row    <= 2'd0;
            r_slot   <= '0;
        end else begin
            r_active <= 1'b1;
            if (r_active) begin
                if (r_slot == SLOT_LAST) begin
                    r_slot <= '0;
                    r_row  <= r_row + 2'd1;
                end else begin
                    r_slot <= r_slot + SW'(1);
                end
            end
        end
    end

    assign keypadr = r_active ? ~(4'b0001 << r_row) : 4'b1111;

    assign w_slot_end  = r_active && (r_slot == SLOT_LAST);
    assign w_frame_end = w_slot_end && (r_row == 2'd3);
    assign w_closed    = ~r_sync2;
    assign w_row_hits  = 2'(w_closed[0]) + 2'(w_closed[1]) + 2'(w_closed[2]);
    assign w_row_code  = key_map(r_row, w_closed);
    assign w_sum       = {1'b0, r_hits} + {1'b0, w_row_hits};
    assign w_acc_hits  = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
    assign w_acc_code  = (r_hits == 2'd0) ? w_row_code : r_hit_code;
    assign w_single    = (w_acc_hits == 2'd1);
    assign w_cnt_inc   = r_cnt + CW'(1);

    // Contact tally saturates at 2: anything beyond one contact is simply MULTI.
    always_ff @(posedge gclk or posedge rst) begin
        if (rst) begin
            r_hits     <= 2'd0;
            r_hit_code <= 4'd0;
        end else if (w_slot_end) begin
            if (r_row == 2'd3) begin
                r_hits     <= 2'd0;
                r_hit_code <= 4'd0;
            end else begin
                r_hits     <= w_acc_hits;
                r_hit_code <= w_acc_code;
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_cand_nx  = r_cand;
        w_press    = 1'b0;
        if (w_frame_end) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_single && (w_acc_code == r_cand)) begin
                        w_cnt_nx = w_cnt_inc;
                    end else if (w_single) begin
                        w_cand_nx = w_acc_code;
                        w_cnt_nx  = CW'(1);
                    end else begin
                        w_cnt_nx = '0;
                    end
                    if (w_cnt_nx == DB_TARGET) begin
                        w_state_nx = ST_PRESSED;
                        w_cnt_nx   = '0;
                        w_press    = 1'b1;
                    end
                end
                ST_PRESSED: begin
                    w_cnt_nx = w_single ? '0 : w_cnt_inc;
                    if (w_cnt_nx == DB_TARGET) begin
                        w_state_nx = ST_IDLE;
                        w_cnt_nx   = '0;
                    end
                end
                default: w_state_nx = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge gclk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_cand  <= 4'd0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_cand  <= w_cand_nx;
        end
    end

    // An ack on the event edge frees the slot, so the new code replaces the old one.
    always_ff @(posedge gclk or posedge rst) begin
        if (rst) begin
            r_key_code  <= 4'd0;
            r_key_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else if (w_press) begin
            if (!r_key_valid || key_ack) begin
                r_key_code  <= w_cand_nx;
                r_key_valid <= 1'b1;
            end else begin
                r_overrun <= 1'b1;
            end
        end else if (key_ack && r_key_valid) begin
            r_key_valid <= 1'b0;
        end
    end

    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_down  = (r_state == ST_PRESSED);
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a keypad contact model, expected key codes
// queued by the stimulus and popped by a monitor whenever a new key is presented.
module tb_keypad_scanner;

    localparam int SCAN_DIV = 4;
    localparam int DEBOUNCE = 2;
    localparam int FRAME    = 16;

    logic       gclk = 1'b0;
    logic       rst = 1'b1;
    logic       key_ack = 1'b0;
    logic [2:0] keypadc;
    logic [3:0] keypadr;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_down;
    logic       overrun;

    logic [11:0] held = '0;
    logic [3:0]  exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          down_rises = 0;

    always #5 gclk = ~gclk;

    keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
        .gclk      (gclk),
        .rst       (rst),
        .keypadc   (keypadc),
        .keypadr   (keypadr),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ack   (key_ack),
        .key_down  (key_down),
        .overrun   (overrun)
    );

    // A closed contact pulls its column low while its row is driven low.
    always_comb begin
        keypadc = 3'b111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 3; c++)
                if (!keypadr[r] && held[r*3+c]) keypadc[c] = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // A key is presented when valid rises, or stays high across an accepting ack edge.
    logic pv = 1'b0, pa = 1'b0, pd = 1'b0;
    always @(negedge gclk) begin
        if (rst) begin
            pv = 1'b0;
            pa = 1'b0;
            pd = 1'b0;
        end else begin
            if (key_valid && (!pv || pa)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_key: got %0h expected none", key_code);
                end else begin
                    check("key_code_mon", key_code, exp_q.pop_front());
                end
            end
            if (key_down && !pd) down_rises++;
            pv = key_valid;
            pa = key_ack && key_valid;
            pd = key_down;
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge gclk);
        #1;
    endtask

    task automatic press(input int r, input int c);
        held[r*3+c] = 1'b1;
    endtask

    task automatic ack_pulse();
        @(posedge gclk); #1 key_ack = 1'b1;
        @(posedge gclk); #1 key_ack = 1'b0;
        @(negedge gclk);
        check("ack_clears_valid", key_valid, 1'b0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_keypadr"}, keypadr, 4'hF);
        check({tag, "_code"}, key_code, 4'h0);
        check({tag, "_valid"}, key_valid, 1'b0);
        check({tag, "_down"}, key_down, 1'b0);
        check({tag, "_overrun"}, overrun, 1'b0);
    endtask

    task automatic check_row_seq(input string tag, input int n);
        logic [3:0] exp_row;
        @(negedge gclk);
        check({tag, "_pre"}, keypadr, 4'hF);
        for (int k = 0; k < n; k++) begin
            @(negedge gclk);
            exp_row = ~(4'b0001 << ((k / SCAN_DIV) % 4));
            check({tag, "_row"}, keypadr, exp_row);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rises0;
        int found;
        logic [3:0] prev;

        // Reset state and scan order.
        repeat (3) @(negedge gclk);
        check_idle_outputs("reset");
        @(posedge gclk); #1 rst = 1'b0;
        check_row_seq("scan", 2 * FRAME);

        // Single press of key 5, release, then ack.
        exp_q.push_back(4'h5);
        press(1, 1);
        wait_cyc(3 * FRAME + 4);
        @(negedge gclk);
        check("p5_down", key_down, 1'b1);
        check("p5_valid", key_valid, 1'b1);
        held = '0;
        wait_cyc(4 * FRAME);
        @(negedge gclk);
        check("p5_released", key_down, 1'b0);
        check("p5_valid_held", key_valid, 1'b1);
        ack_pulse();
        check("p5_code_holds", key_code, 4'h5);

        // Bouncing '*' produces nothing; stable '*' produces one event.
        rises0 = down_rises;
        for (int i = 0; i < 4; i++) begin
            press(3, 0);
            wait_cyc(FRAME);
            held = '0;
            wait_cyc(FRAME);
        end
        check("bounce_valid", key_valid, 1'b0);
        check("bounce_down_rises", down_rises, rises0);
        exp_q.push_back(4'hE);
        press(3, 0);
        wait_cyc(4 * FRAME);
        held = '0;
        wait_cyc(4 * FRAME);
        @(negedge gclk);
        check("star_down_once", down_rises, rises0 + 1);
        check("star_code", key_code, 4'hE);
        check("star_released", key_down, 1'b0);
        ack_pulse();

        // Two keys together never register.
        press(0, 0);
        press(2, 2);
        wait_cyc(4 * FRAME);
        check("ghost_valid", key_valid, 1'b0);
        check("ghost_down", key_down, 1'b0);
        held = '0;
        wait_cyc(4 * FRAME);

        // Rollover: '#' added while '1' is held gives no second event.
        exp_q.push_back(4'h1);
        press(0, 0);
        wait_cyc(4 * FRAME);
        check("roll_down", key_down, 1'b1);
        press(3, 2);
        wait_cyc(4 * FRAME);
        check("roll_multi_release", key_down, 1'b0);
        held = '0;
        wait_cyc(4 * FRAME);
        check("roll_code", key_code, 4'h1);
        check("roll_valid", key_valid, 1'b1);
        ack_pulse();

        // Overrun: 7 then 8 without ack keeps 7.
        exp_q.push_back(4'h7);
        press(2, 0);
        wait_cyc(4 * FRAME);
        held = '0;
        wait_cyc(4 * FRAME);
        press(2, 1);
        wait_cyc(4 * FRAME);
        held = '0;
        wait_cyc(4 * FRAME);
        check("ovr_code", key_code, 4'h7);
        check("ovr_flag", overrun, 1'b1);
        check("ovr_valid", key_valid, 1'b1);
        ack_pulse();
        exp_q.push_back(4'hF);
        press(3, 2);
        wait_cyc(4 * FRAME);
        held = '0;
        wait_cyc(4 * FRAME);
        check("hash_code", key_code, 4'hF);
        check("ovr_sticky", overrun, 1'b1);

        // Reset clears overrun, then event and ack on the same edge.
        rst = 1'b1;
        #1;
        check("rst_overrun", overrun, 1'b0);
        check("rst_valid", key_valid, 1'b0);
        @(posedge gclk); #1 rst = 1'b0;
        exp_q.push_back(4'h4);
        press(1, 0);
        wait_cyc(4 * FRAME);
        held = '0;
        wait_cyc(4 * FRAME);
        check("p4_valid", key_valid, 1'b1);

        found = 0;
        prev = keypadr;
        for (int i = 0; i < 3 * FRAME && found == 0; i++) begin
            @(negedge gclk);
            if (keypadr == 4'b1110 && prev == 4'b0111) found = 1;
            prev = keypadr;
        end
        check("frame_sync", found, 1);
        // Frame-start edge was one half-cycle ago; the press is accepted 2 frames later.
        exp_q.push_back(4'h9);
        press(2, 2);
        repeat (2 * FRAME - 1) @(posedge gclk);
        #1 key_ack = 1'b1;
        @(posedge gclk); #1 key_ack = 1'b0;
        @(negedge gclk);
        check("sim_valid", key_valid, 1'b1);
        check("sim_code", key_code, 4'h9);
        check("sim_overrun", overrun, 1'b0);
        check("sim_down", key_down, 1'b1);

        // Mid-frame reset with the key still held.
        wait_cyc(5);
        rst = 1'b1;
        #2;
        check_idle_outputs("midrst");
        held = '0;
        wait_cyc(2);
        rst = 1'b0;
        check_row_seq("restart", 8);

        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
